// File: rtl/br_wr_arbiter_if.sv
// Writeback request channels (ALU, load unit) and the single BR write port.
// Arbiter drives ready/busy/br_*; the requester side drives valid/addr/data.
interface br_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          busy;
  logic          br_we;
  logic [AW-1:0] br_a3;
  logic [DW-1:0] br_wd3;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, busy, br_we, br_a3, br_wd3
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, busy, br_we, br_a3, br_wd3
  );
endinterface

// File: rtl/br_wr_arbiter.sv
// Clears x1..x(2**AW-1) after reset, then round-robins BR's write port between two requesters.
// One registered stage (accept N, write on port N+1); ready is held low during the clear.
module br_wr_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  br_wr_arbiter_if.slave  bus
);
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
  } br_wr_t;

  localparam state_e        ST_RST     = INIT_CLEAR ? ST_INIT : ST_RUN;
  localparam logic [AW-1:0] PTR_FIRST  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST   = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  br_wr_t        wr_q, wr_d;

  logic          grant;
  logic          acc0;
  logic          acc1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      ptr_q   <= PTR_FIRST;
      last_q  <= 1'b1;
      busy_q  <= INIT_CLEAR;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    busy_d  = busy_q;
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    if (state_q == ST_INIT) begin
      wr_d.we  = 1'b1;
      wr_d.a3  = ptr_q;
      wr_d.wd3 = '0;
      ptr_d    = ptr_q + PTR_FIRST;
      if (ptr_q == PTR_LAST) begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    end else if (acc0) begin
      // x0 is architecturally zero: the handshake completes but nothing is written
      wr_d.we  = |bus.req0_addr;
      wr_d.a3  = bus.req0_addr;
      wr_d.wd3 = bus.req0_data;
      last_d   = 1'b0;
    end else if (acc1) begin
      wr_d.we  = |bus.req1_addr;
      wr_d.a3  = bus.req1_addr;
      wr_d.wd3 = bus.req1_data;
      last_d   = 1'b1;
    end
  end

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
    acc0 = (state_q == ST_RUN) && bus.req0_valid && !grant;
    acc1 = (state_q == ST_RUN) && bus.req1_valid &&  grant;
  end

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.busy       = busy_q;
  assign bus.br_we      = wr_q.we;
  assign bus.br_a3      = wr_q.a3;
  assign bus.br_wd3     = wr_q.wd3;
endmodule

// File: tb/tb_br_wr_arbiter.sv
// Bench for br_wr_arbiter: directed scenarios plus a randomized run against a
// behavioural round-robin model and a bench-side register file.
module tb_br_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [DW-1:0] br_mem [32] = '{default: 32'hDEADBEEF};

  br_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  br_wr_arbiter #(.AW(AW), .DW(DW), .INIT_CLEAR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.br_we) br_mem[bus.br_a3] <= bus.br_wd3;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0_valid = v;
    bus.req0_addr  = a;
    bus.req0_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1_valid = v;
    bus.req1_addr  = a;
    bus.req1_data  = d;
  endtask

  task automatic reset_and_clear();
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (31) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    rst_n = 1'b0;
    #12;
    vectors++;
    if (bus.br_we !== 1'b0 || bus.br_a3 !== '0 || bus.br_wd3 !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: we=%0b a3=%0d wd3=%h, required 0/0/0", bus.br_we, bus.br_a3, bus.br_wd3);
    end
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: busy=%0b, required 1", bus.busy);
    end
  endtask

  // Clear sequence with a request parked on req0 for its whole duration.
  task automatic test_init_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive0(1'b1, 5'd10, 32'h12);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.req0_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL init_ready0 cycle %0d: ready0=%0b, required 0", k, bus.req0_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.br_we !== 1'b1 || bus.br_a3 !== 5'(k) || bus.br_wd3 !== '0 || bus.busy !== (k < 31)) begin
        miscompares++;
        $display("FAIL init_write cycle %0d: we=%0b a3=%0d wd3=%h busy=%0b, required 1/%0d/0/%0b",
                 k, bus.br_we, bus.br_a3, bus.br_wd3, bus.busy, k, k < 31);
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL first_run_ready0: ready0=%0b, required 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    drive0(1'b0, '0, '0);
    vectors++;
    if (bus.br_we !== 1'b1 || bus.br_a3 !== 5'd10 || bus.br_wd3 !== 32'h12) begin
      miscompares++;
      $display("FAIL held_req_write: we=%0b a3=%0d wd3=%h, required 1/10/12", bus.br_we, bus.br_a3, bus.br_wd3);
    end
    for (int r = 1; r < 32; r++) begin
      vectors++;
      if (br_mem[r] !== '0) begin
        miscompares++;
        $display("FAIL clear_readback x%0d: %h, required 0", r, br_mem[r]);
      end
    end
  endtask

  task automatic test_alternate();
    reset_and_clear();
    drive0(1'b1, 5'd5, 32'hF00F);
    drive1(1'b1, 5'd21, 32'hABC);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL alt_grant %0d: ready0=%0b ready1=%0b, required grant %0d", i, bus.req0_ready, bus.req1_ready, i % 2);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.br_we !== 1'b1 || bus.br_a3 !== ((i % 2 == 0) ? 5'd5 : 5'd21) ||
          bus.br_wd3 !== ((i % 2 == 0) ? 32'hF00F : 32'hABC)) begin
        miscompares++;
        $display("FAIL alt_write %0d: we=%0b a3=%0d wd3=%h", i, bus.br_we, bus.br_a3, bus.br_wd3);
      end
    end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    @(posedge clk); #1;
    vectors++;
    if (bus.br_we !== 1'b0 || bus.br_a3 !== 5'd21 || bus.br_wd3 !== 32'hABC) begin
      miscompares++;
      $display("FAIL idle_hold: we=%0b a3=%0d wd3=%h, required 0/21/abc", bus.br_we, bus.br_a3, bus.br_wd3);
    end
  endtask

  task automatic test_x0_write();
    drive1(1'b1, 5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    vectors++;
    if (bus.req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_ready1: ready1=%0b, required 1", bus.req1_ready);
    end
    @(posedge clk); #1;
    drive1(1'b0, '0, '0);
    vectors++;
    if (bus.br_we !== 1'b0 || bus.br_a3 !== 5'd0 || bus.br_wd3 !== 32'hFFFFFFFF) begin
      miscompares++;
      $display("FAIL x0_port: we=%0b a3=%0d wd3=%h, required 0/0/ffffffff", bus.br_we, bus.br_a3, bus.br_wd3);
    end
    @(posedge clk); #1;
    vectors++;
    if (br_mem[0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL x0_unwritten: x0 storage=%h, required deadbeef", br_mem[0]);
    end
  endtask

  task automatic test_same_addr();
    drive0(1'b1, 5'd3, 32'h3);
    @(negedge clk);
    @(posedge clk); #1;
    drive0(1'b1, 5'd7, 32'h1);
    drive1(1'b1, 5'd7, 32'h2);
    @(negedge clk);
    vectors++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL same_addr_first: ready0=%0b ready1=%0b, required 0/1", bus.req0_ready, bus.req1_ready);
    end
    @(posedge clk); #1;
    drive1(1'b0, '0, '0);
    vectors++;
    if (bus.br_we !== 1'b1 || bus.br_a3 !== 5'd7 || bus.br_wd3 !== 32'h2) begin
      miscompares++;
      $display("FAIL same_addr_w1: we=%0b a3=%0d wd3=%h, required 1/7/2", bus.br_we, bus.br_a3, bus.br_wd3);
    end
    @(negedge clk);
    vectors++;
    if (bus.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_addr_second: ready0=%0b, required 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    drive0(1'b0, '0, '0);
    @(posedge clk); #1;
    vectors++;
    if (br_mem[7] !== 32'h1) begin
      miscompares++;
      $display("FAIL same_addr_final: x7=%h, required 1", br_mem[7]);
    end
  endtask

  task automatic test_reset_mid_init();
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.br_we !== 1'b0 || bus.br_a3 !== '0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: we=%0b a3=%0d busy=%0b, required 0/0/1", bus.br_we, bus.br_a3, bus.busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.br_we !== 1'b1 || bus.br_a3 !== 5'(k)) begin
        miscompares++;
        $display("FAIL restart_write cycle %0d: we=%0b a3=%0d, required 1/%0d", k, bus.br_we, bus.br_a3, k);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.br_we !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_end: we=%0b busy=%0b, required 0/0", bus.br_we, bus.busy);
    end
  endtask

  // Random traffic: each requester keeps its request until it is granted.
  task automatic test_random();
    logic          v[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    logic [DW-1:0] model_mem [32];
    int            last_m;
    int            g;
    logic [AW-1:0] exp_a3;
    logic [DW-1:0] exp_wd3;
    exp_a3  = 5'd31;
    exp_wd3 = '0;
    last_m  = 1;
    for (int r = 0; r < 32; r++) model_mem[r] = '0;
    for (int q = 0; q < 2; q++) begin
      v[q] = 1'b0; a[q] = '0; d[q] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int q = 0; q < 2; q++) begin
        if (!v[q] && $urandom_range(0, 3) != 0) begin
          v[q] = 1'b1;
          a[q] = 5'($urandom_range(0, 31));
          d[q] = $urandom;
        end
      end
      drive0(v[0], a[0], d[0]);
      drive1(v[1], a[1], d[1]);
      g = -1;
      if (v[0] && v[1]) g = 1 - last_m;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
      @(negedge clk);
      vectors++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
        miscompares++;
        $display("FAIL rnd_ready cycle %0d: ready0=%0b ready1=%0b, required grant %0d", c, bus.req0_ready, bus.req1_ready, g);
      end
      @(posedge clk); #1;
      if (g >= 0) begin
        exp_a3  = a[g];
        exp_wd3 = d[g];
        if (a[g] != 0) model_mem[a[g]] = d[g];
        last_m = g;
        v[g]   = 1'b0;
      end
      vectors++;
      if (bus.br_we !== (g >= 0 && exp_a3 != 0) || bus.br_a3 !== exp_a3 || bus.br_wd3 !== exp_wd3) begin
        miscompares++;
        $display("FAIL rnd_port cycle %0d: we=%0b a3=%0d wd3=%h, required a3=%0d wd3=%h", c, bus.br_we, bus.br_a3, bus.br_wd3, exp_a3, exp_wd3);
      end
    end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    @(posedge clk); #1;
    for (int r = 1; r < 32; r++) begin
      vectors++;
      if (br_mem[r] !== model_mem[r]) begin
        miscompares++;
        $display("FAIL rnd_readback x%0d: %h, required %h", r, br_mem[r], model_mem[r]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_init_clear();
    test_alternate();
    test_x0_write();
    test_same_addr();
    test_reset_mid_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
